// File: rtl/state_dump_unit.sv
// Purpose : after a program run, stream every GPR, then every data-memory word, out on a valid/ready port.
// Latency : start edge E -> busy at E+1 -> first word presented after E+1; registers 1/cycle, memory 1 per 2 cycles.
// Backpr. : a single output slot; while out_valid_o && !out_ready_i the slot holds and no new read is issued.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   start_i               begin a dump (only honoured in IDLE, not during the done cycle)
//   busy_o, done_o        dump in progress / one-cycle completion pulse
//   rf_addr_o, rf_data_i  register-file read port (combinational data)
//   dm_addr_o, dm_rd_en_o, dm_data_i  data-memory read port (data the cycle after dm_rd_en_o)
//   out_valid_o, out_ready_i, out_data_o, out_is_mem_o, out_last_o  dumped word stream
module state_dump_unit #(
    parameter int CPU_DATA_WIDTH              = 32,
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5,
    parameter int DATA_ADDRESS_WIDTH          = 6
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] rf_addr_o,
    input  logic [CPU_DATA_WIDTH-1:0]              rf_data_i,
    output logic [DATA_ADDRESS_WIDTH-1:0]          dm_addr_o,
    output logic                                   dm_rd_en_o,
    input  logic [CPU_DATA_WIDTH-1:0]              dm_data_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [CPU_DATA_WIDTH-1:0]              out_data_o,
    output logic                                   out_is_mem_o,
    output logic                                   out_last_o
);

    localparam int RFW = REGISTER_FILE_ADDRESS_WIDTH;
    localparam int DAW = DATA_ADDRESS_WIDTH;
    localparam int DW  = CPU_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    // One bit wider than the address: the MSB flags that the last entry was read.
    logic [RFW:0]    rf_cnt_q, rf_cnt_d;
    logic [DAW:0]    dm_cnt_q, dm_cnt_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic            is_mem_q, is_mem_d;
    logic            last_q, last_d;
    logic            dm_rd_en;

    logic            slot_free;
    logic            xfer;
    logic [RFW:0]    rf_cnt_nxt;
    logic [DAW:0]    dm_cnt_nxt;

    // The slot may be refilled on the same edge its current word leaves.
    assign xfer       = valid_q & out_ready_i;
    assign slot_free  = ~valid_q | out_ready_i;
    assign rf_cnt_nxt = rf_cnt_q + 1'b1;
    assign dm_cnt_nxt = dm_cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rf_cnt_d = rf_cnt_q;
        dm_cnt_d = dm_cnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        is_mem_d = is_mem_q;
        last_d   = last_q;
        dm_rd_en = 1'b0;

        if (xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // done_q marks the completion cycle, during which start is ignored.
                if (start_i && !done_q) begin
                    state_d  = S_REG;
                    busy_d   = 1'b1;
                    rf_cnt_d = '0;
                    dm_cnt_d = '0;
                end
            end
            S_REG: begin
                if (slot_free) begin
                    data_d   = rf_data_i;
                    valid_d  = 1'b1;
                    is_mem_d = 1'b0;
                    last_d   = 1'b0;
                    rf_cnt_d = rf_cnt_nxt;
                    if (rf_cnt_nxt[RFW]) begin
                        state_d = S_MEM_REQ;
                    end
                end
            end
            S_MEM_REQ: begin
                // Only read when the returning word is guaranteed a free slot.
                if (slot_free) begin
                    dm_rd_en = 1'b1;
                    state_d  = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                // The slot was free when the read was issued, so it is empty now.
                data_d   = dm_data_i;
                valid_d  = 1'b1;
                is_mem_d = 1'b1;
                last_d   = (dm_cnt_q[DAW-1:0] == {DAW{1'b1}});
                dm_cnt_d = dm_cnt_nxt;
                state_d  = dm_cnt_nxt[DAW] ? S_DRAIN : S_MEM_REQ;
            end
            S_DRAIN: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rf_cnt_q <= '0;
            dm_cnt_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            is_mem_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rf_cnt_q <= rf_cnt_d;
            dm_cnt_q <= dm_cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            is_mem_q <= is_mem_d;
            last_q   <= last_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign rf_addr_o    = rf_cnt_q[RFW-1:0];
    assign dm_addr_o    = dm_cnt_q[DAW-1:0];
    assign dm_rd_en_o   = dm_rd_en;
    assign out_valid_o  = valid_q;
    assign out_data_o   = data_q;
    assign out_is_mem_o = is_mem_q;
    assign out_last_o   = last_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: instance 0 at default sizes (96 words), instance 1 with 8 memory words (40 words).
// Expected stream, busy/done timing and read-port behaviour come from a stream-level model kept here.
// Inputs are driven 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_state_dump_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic        start    [2];
    logic        busy     [2];
    logic        done     [2];
    logic [4:0]  rf_addr  [2];
    logic [31:0] rf_data  [2];
    logic [5:0]  dm_addr  [2];
    logic [2:0]  dm_addr3;
    logic        dm_rd_en [2];
    logic [31:0] dm_data  [2];
    logic        out_valid[2];
    logic [31:0] out_data [2];
    logic        out_is_mem[2];
    logic        out_last [2];

    logic [31:0] regs [2][32];
    logic [31:0] mem  [2][64];

    always #5 clk = ~clk;

    state_dump_unit dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .rf_addr_o(rf_addr[0]), .rf_data_i(rf_data[0]),
        .dm_addr_o(dm_addr[0]), .dm_rd_en_o(dm_rd_en[0]), .dm_data_i(dm_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_data_o(out_data[0]),
        .out_is_mem_o(out_is_mem[0]), .out_last_o(out_last[0])
    );

    state_dump_unit #(.DATA_ADDRESS_WIDTH(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .rf_addr_o(rf_addr[1]), .rf_data_i(rf_data[1]),
        .dm_addr_o(dm_addr3), .dm_rd_en_o(dm_rd_en[1]), .dm_data_i(dm_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_data_o(out_data[1]),
        .out_is_mem_o(out_is_mem[1]), .out_last_o(out_last[1])
    );

    assign dm_addr[1] = {3'b000, dm_addr3};
    assign rf_data[0] = regs[0][rf_addr[0]];
    assign rf_data[1] = regs[1][rf_addr[1]];

    always @(posedge clk) begin
        if (dm_rd_en[0]) dm_data[0] <= mem[0][dm_addr[0]];
        if (dm_rd_en[1]) dm_data[1] <= mem[1][dm_addr3];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk($sformatf("%s_ctl%0d", tag, k),
            {26'd0, busy[k], done[k], dm_rd_en[k], out_valid[k], out_is_mem[k], out_last[k]}, 32'd0);
        chk($sformatf("%s_addr%0d", tag, k), {21'd0, rf_addr[k], dm_addr[k]}, 32'd0);
        chk($sformatf("%s_data%0d", tag, k), out_data[k], 32'd0);
    endtask

    // ---------------- stream-level model ----------------
    int          idx  [2];
    int          rdc  [2];
    int          e_st [2];
    bit          busy_m[2], done_m[2], stalled[2], pst[2], prd[2];
    logic [31:0] pdat [2];
    logic        pmem [2], plast[2];
    logic [5:0]  pad  [2];
    bit          lit_mode = 1'b0;

    function automatic int nwords(input int k);
        return (k == 0) ? 96 : 40;
    endfunction

    function automatic int nmem(input int k);
        return (k == 0) ? 64 : 8;
    endfunction

    function automatic logic [31:0] expw(input int k, input int i);
        return (i < 32) ? regs[k][i] : mem[k][i-32];
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk_zero(k, "rst");
                busy_m[k] = 0; done_m[k] = 0; idx[k] = 0; rdc[k] = 0;
                pst[k] = 0; prd[k] = 0;
            end else begin
                bit xf;
                bit nd;
                chk($sformatf("busy%0d", k), {31'd0, busy[k]}, {31'd0, busy_m[k]});
                chk($sformatf("done%0d", k), {31'd0, done[k]}, {31'd0, done_m[k]});
                if (!busy_m[k]) chk($sformatf("idle_valid%0d", k), {31'd0, out_valid[k]}, 32'd0);
                if (pst[k]) begin
                    chk($sformatf("hold_valid%0d", k), {31'd0, out_valid[k]}, 32'd1);
                    chk($sformatf("hold_data%0d", k), out_data[k], pdat[k]);
                    chk($sformatf("hold_flags%0d", k), {30'd0, out_is_mem[k], out_last[k]},
                        {30'd0, pmem[k], plast[k]});
                end
                if (prd[k]) begin
                    chk($sformatf("rd_once%0d", k), {31'd0, dm_rd_en[k]}, 32'd0);
                    chk($sformatf("dm_addr_hold%0d", k), {26'd0, dm_addr[k]}, {26'd0, pad[k]});
                end
                if (dm_rd_en[k]) begin
                    chk($sformatf("rd_legal%0d", k),
                        {31'd0, busy_m[k] && !(out_valid[k] && !out_ready)}, 32'd1);
                    chk($sformatf("rd_addr%0d", k), {26'd0, dm_addr[k]}, rdc[k] % nmem(k));
                    rdc[k]++;
                end
                xf = out_valid[k] && out_ready;
                if (xf) begin
                    if (idx[k] >= nwords(k)) begin
                        chk($sformatf("extra_word%0d", k), idx[k], nwords(k) - 1);
                    end else begin
                        chk($sformatf("w%0d_%0d", k, idx[k]), out_data[k], expw(k, idx[k]));
                        chk($sformatf("w%0d_%0d_flags", k, idx[k]), {30'd0, out_is_mem[k], out_last[k]},
                            {30'd0, idx[k] >= 32, idx[k] == nwords(k) - 1});
                        if (!stalled[k])
                            chk($sformatf("w%0d_%0d_edge", k, idx[k]), cyc - e_st[k],
                                (idx[k] < 32) ? 2 + idx[k] : 35 + 2 * (idx[k] - 32));
                        if (lit_mode && k == 0) begin
                            if (idx[k] == 1)  chk("lit_r1", out_data[0], 32'd3);
                            if (idx[k] == 31) chk("lit_r31", out_data[0], 32'd93);
                            if (idx[k] == 32) chk("lit_m0", out_data[0], 32'hFFFF_FFFF);
                            if (idx[k] == 95) chk("lit_m63", out_data[0], 32'hFFFF_FFC0);
                            if (idx[k] == 95) chk("lit_last_edge0", cyc - e_st[0], 32'd161);
                        end
                        if (lit_mode && k == 1 && idx[k] == 39)
                            chk("lit_last_edge1", cyc - e_st[1], 32'd49);
                    end
                    idx[k]++;
                end
                if (busy_m[k] && !out_ready) stalled[k] = 1;
                pst[k]   = out_valid[k] && !out_ready;
                pdat[k]  = out_data[k];
                pmem[k]  = out_is_mem[k];
                plast[k] = out_last[k];
                prd[k]   = dm_rd_en[k];
                pad[k]   = dm_addr[k];
                nd = 0;
                if (xf && busy_m[k] && idx[k] == nwords(k)) begin
                    nd = 1;
                    busy_m[k] = 0;
                end else if (!busy_m[k] && !done_m[k] && start[k]) begin
                    busy_m[k] = 1; idx[k] = 0; rdc[k] = 0; stalled[k] = 0; e_st[k] = cyc;
                end
                done_m[k] = nd;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit s0, input bit s1);
        start[0] = s0; start[1] = s1;
        tick();
        start[0] = 0; start[1] = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy_m[0] || busy_m[1] || done_m[0] || done_m[1]) && n < 2000) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, {31'd0, n >= 2000}, 32'd0);
    endtask

    task automatic wait_word(input int k, input int w);
        int n = 0;
        while (idx[k] < w && n < 1000) begin
            tick();
            n++;
        end
        chk($sformatf("wait_word%0d_%0d_timeout", k, w), {31'd0, n >= 1000}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; start[0] = 0; start[1] = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) regs[k][i] = 3 * i;
            for (int j = 0; j < 64; j++) mem[k][j] = ~j;
        end
        dm_data[0] = '0; dm_data[1] = '0;

        // Reset held for 3 cycles.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Full dump at full speed with fixed patterns.
        lit_mode = 1;
        pulse_start(1, 1);
        chk("lit_busy_after_start", {31'd0, busy[0]}, 32'd1);
        chk("lit_rf_addr_after_start", {27'd0, rf_addr[0]}, 32'd0);
        wait_idle("full");
        lit_mode = 0;
        tick();
        chk("lit_dm_addr_wrap1", {29'd0, dm_addr3}, 32'd0);
        chk("lit_dm_addr_wrap0", {26'd0, dm_addr[0]}, 32'd0);

        // Backpressure at words 10 and 40.
        pulse_start(1, 1);
        wait_word(0, 10);
        out_ready = 0; repeat (5) tick(); out_ready = 1;
        wait_word(0, 40);
        out_ready = 0; repeat (5) tick(); out_ready = 1;
        wait_idle("bp");

        // Random data, random backpressure, stray starts while busy.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) regs[k][i] = $urandom;
            for (int j = 0; j < 64; j++) mem[k][j] = $urandom;
        end
        pulse_start(1, 1);
        for (int n = 0; n < 3000 && (busy_m[0] || busy_m[1]); n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start[0] = busy_m[0] && ($urandom_range(0, 15) == 0);
            start[1] = busy_m[1] && ($urandom_range(0, 15) == 0);
            tick();
        end
        start[0] = 0; start[1] = 0; out_ready = 1;
        wait_idle("rand");

        // start during busy (word 20) and during the done cycle, then a second stream.
        pulse_start(1, 0);
        wait_word(0, 20);
        pulse_start(1, 0);
        begin
            int n = 0;
            while (!done[0] && n < 1000) begin
                tick();
                n++;
            end
            chk("done_wait_timeout", {31'd0, n >= 1000}, 32'd0);
        end
        pulse_start(1, 0);
        chk("start_in_done_ignored", {31'd0, busy[0]}, 32'd0);
        pulse_start(1, 0);
        wait_idle("restart");

        // Reset in the middle of a dump.
        pulse_start(1, 1);
        wait_word(0, 40);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "midrst");
        chk_zero(1, "midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pulse_start(1, 1);
        wait_idle("after_rst");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
